// File: rtl/dmem_bytelane.sv
// dmem_bytelane: byte-lane addressable data memory with sign/zero-extending
// loads and alignment checking.
//
// Parameters
//   ADDR_W          word-index width, memory depth is 2**ADDR_W 32-bit words
//   CLEAR_ON_RESET  when 1, all words are zero-filled after reset
//
// Ports
//   clk     system clock, rising edge
//   reset   synchronous active-high reset
//   req     access request, accepted when ready=1
//   we      1 = store, 0 = load
//   size    00 byte, 01 halfword, 10 word, 11 illegal
//   uns     load zero-extends when 1, sign-extends when 0
//   a       byte address (bits above ADDR_W+1 ignored)
//   wd      store data, right-aligned
//   ready   block accepts requests
//   rvalid  rd carries a load result this cycle
//   rd      extended load data, held while rvalid=0
//   err     one-cycle pulse after a misaligned/illegal access
module dmem_bytelane #(
    parameter int ADDR_W         = 11,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic        ready,
    output logic        rvalid,
    output logic [31:0] rd,
    output logic        err
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   cnt;
    logic [31:0]         mem [DEPTH];

    logic [ADDR_W-1:0]   widx;
    logic [1:0]          lane;
    logic                accept;
    logic                bad;

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_idx;
    logic [3:0]          mem_be;
    logic [31:0]         mem_wdata;

    // Upper address bits are deliberately ignored so addresses wrap.
    logic                unused_addr;
    assign unused_addr = ^a[31:ADDR_W+2];

    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] ln);
        case (sz)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = ln[0];
            2'b10:   misaligned = (ln != 2'b00);
            default: misaligned = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] sz, input logic [1:0] ln);
        case (sz)
            2'b00:   store_be = 4'b0001 << ln;
            2'b01:   store_be = ln[1] ? 4'b1100 : 4'b0011;
            default: store_be = 4'b1111;
        endcase
    endfunction

    // Replicating the right-aligned data lets the byte enables pick the lane.
    function automatic logic [31:0] store_data(input logic [1:0] sz, input logic [31:0] d);
        case (sz)
            2'b00:   store_data = {4{d[7:0]}};
            2'b01:   store_data = {2{d[15:0]}};
            default: store_data = d;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] sz,
                                                input logic [1:0] ln, input logic zext);
        logic [31:0] sh;
        sh = word >> {ln, 3'b000};
        case (sz)
            2'b00:   load_extend = zext ? {24'h0, sh[7:0]}   : {{24{sh[7]}}, sh[7:0]};
            2'b01:   load_extend = zext ? {16'h0, sh[15:0]}  : {{16{sh[15]}}, sh[15:0]};
            default: load_extend = word;
        endcase
    endfunction

    assign ready  = (state == IDLE);
    assign widx   = a[ADDR_W+1:2];
    assign lane   = a[1:0];
    assign accept = req && ready && !reset;
    assign bad    = misaligned(size, lane);

    // Single write port shared by the clear sweep and stores; reset itself
    // never writes memory.
    always_comb begin
        mem_we    = 1'b0;
        mem_idx   = widx;
        mem_be    = 4'b0000;
        mem_wdata = 32'h0;
        if (!reset) begin
            if (state == CLEAR) begin
                mem_we  = 1'b1;
                mem_idx = cnt;
                mem_be  = 4'b1111;
            end else if (accept && we && !bad) begin
                mem_we    = 1'b1;
                mem_be    = store_be(size, lane);
                mem_wdata = store_data(size, wd);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_be[i]) mem[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
    end

    // Loads read the array at acceptance, so a store accepted on the
    // previous edge is already visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= CLEAR_ON_RESET ? CLEAR : IDLE;
            cnt    <= '0;
            rvalid <= 1'b0;
            err    <= 1'b0;
            rd     <= 32'h0;
        end else begin
            rvalid <= 1'b0;
            err    <= 1'b0;
            case (state)
                CLEAR: begin
                    if (&cnt) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (accept) begin
                        if (bad) begin
                            err <= 1'b1;
                        end else if (!we) begin
                            rvalid <= 1'b1;
                            rd     <= load_extend(mem[widx], size, lane, uns);
                        end
                    end
                end
            endcase
        end
    end

endmodule
